cvxif_result_scheduler: RTL

Result-path scheduler for CV-X-IF coprocessors that host several functional units behind one result interface. It tracks the issue and commit state of every instruction id, releases a unit's result only once the core has committed that id, and silently drains results of killed ids. Committed results from up to `NrUnits` units are arbitrated round-robin onto a single registered `x_result` channel. It sits between the coprocessor's issue decoder and FIFOs on one side and `cvxif_resp_o.x_result*` on the other.

---
 rtl/cvxif_result_scheduler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cvxif_result_scheduler.sv
// rtl/cvxif_result_scheduler.sv - CV-X-IF result scheduler: commit-gated release, kill drain, round-robin output
module cvxif_result_scheduler #(
  parameter int unsigned NrUnits   = 4,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned DataWidth = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          issue_accept_i,
  input  logic [IdWidth-1:0]            issue_id_i,
  input  logic                          commit_valid_i,
  input  logic [IdWidth-1:0]            commit_id_i,
  input  logic                          commit_kill_i,
  input  logic [NrUnits-1:0]            unit_valid_i,
  output logic [NrUnits-1:0]            unit_ready_o,
  input  logic [NrUnits*IdWidth-1:0]    unit_id_i,
  input  logic [NrUnits*DataWidth-1:0]  unit_data_i,
  input  logic [NrUnits*5-1:0]          unit_rd_i,
  input  logic [NrUnits-1:0]            unit_we_i,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic [IdWidth-1:0]            result_id_o,
  output logic [DataWidth-1:0]          result_data_o,
  output logic [4:0]                    result_rd_o,
  output logic                          result_we_o,
  output logic                          result_exc_o,
  output logic                          protocol_err_o
);

  localparam int unsigned NrIds = 1 << IdWidth;
  localparam int unsigned RrW   = (NrUnits > 1) ? $clog2(NrUnits) : 1;

  typedef enum logic [1:0] {
    SB_FREE      = 2'd0,
    SB_ISSUED    = 2'd1,
    SB_COMMITTED = 2'd2,
    SB_KILLED    = 2'd3
  } sb_state_e;

  sb_state_e sb_q [NrIds];
  sb_state_e sb_d [NrIds];

  logic [RrW-1:0]       rr_q;
  logic [RrW-1:0]       rr_next;
  logic                 out_valid_q;
  logic [IdWidth-1:0]   out_id_q;
  logic [DataWidth-1:0] out_data_q;
  logic [4:0]           out_rd_q;
  logic                 out_we_q;
  logic                 err_q;
  logic                 err_set;

  logic [NrUnits-1:0]   elig;
  logic [NrUnits-1:0]   drop;
  logic [NrUnits-1:0]   dup;
  logic [NrUnits-1:0]   grant_oh;
  logic                 grant_valid;
  logic [RrW-1:0]       grant_idx;
  logic [RrW-1:0]       cand;
  logic                 can_load;
  logic                 load;

  logic [IdWidth-1:0]   win_id;
  logic [DataWidth-1:0] win_data;
  logic [4:0]           win_rd;
  logic                 win_we;

  // Classify each unit from registered scoreboard state; a repeated id only counts for its lowest-index holder
  always_comb begin
    elig = '0;
    drop = '0;
    dup  = '0;
    for (int u = 0; u < NrUnits; u++) begin
      for (int v = 0; v < u; v++) begin
        if (unit_valid_i[u] && unit_valid_i[v] &&
            (unit_id_i[u*IdWidth +: IdWidth] == unit_id_i[v*IdWidth +: IdWidth])) begin
          dup[u] = 1'b1;
        end
      end
      if (unit_valid_i[u] && !dup[u]) begin
        elig[u] = (sb_q[unit_id_i[u*IdWidth +: IdWidth]] == SB_COMMITTED);
        drop[u] = (sb_q[unit_id_i[u*IdWidth +: IdWidth]] == SB_KILLED);
      end
    end
  end

  // Round-robin pick: scan offsets from the far end so the smallest offset from rr_q wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = NrUnits - 1; i >= 0; i--) begin
      cand = RrW'((int'(rr_q) + i) % int'(NrUnits));
      if (elig[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign can_load = !out_valid_q || result_ready_i;
  assign load     = grant_valid && can_load;
  assign rr_next  = (int'(grant_idx) == int'(NrUnits) - 1) ? '0 : grant_idx + 1'b1;

  // Select the winner's payload and form the per-unit acknowledge
  always_comb begin
    win_id   = '0;
    win_data = '0;
    win_rd   = '0;
    win_we   = 1'b0;
    grant_oh = '0;
    for (int u = 0; u < NrUnits; u++) begin
      if (RrW'(u) == grant_idx) begin
        win_id   = unit_id_i[u*IdWidth +: IdWidth];
        win_data = unit_data_i[u*DataWidth +: DataWidth];
        win_rd   = unit_rd_i[u*5 +: 5];
        win_we   = unit_we_i[u];
        grant_oh[u] = load;
      end
    end
  end

  assign unit_ready_o = drop | grant_oh;

  // Scoreboard next state; free events, issue and commit never target the same entry in a legal cycle
  always_comb begin
    sb_d    = sb_q;
    err_set = |dup;
    for (int u = 0; u < NrUnits; u++) begin
      if (drop[u]) begin
        sb_d[unit_id_i[u*IdWidth +: IdWidth]] = SB_FREE;
      end
    end
    if (load) begin
      sb_d[win_id] = SB_FREE;
    end
    if (issue_accept_i) begin
      if (sb_q[issue_id_i] == SB_FREE) begin
        sb_d[issue_id_i] = SB_ISSUED;
      end else begin
        err_set = 1'b1;
      end
    end
    if (commit_valid_i) begin
      if (sb_q[commit_id_i] == SB_ISSUED) begin
        sb_d[commit_id_i] = commit_kill_i ? SB_KILLED : SB_COMMITTED;
      end else begin
        err_set = 1'b1;
      end
    end
  end

  // Scoreboard, arbitration pointer and sticky error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrIds; i++) begin
        sb_q[i] <= SB_FREE;
      end
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sb_q  <= sb_d;
      err_q <= err_q | err_set;
      if (load) begin
        rr_q <= rr_next;
      end
    end
  end

  // Output register: loads when empty or draining, otherwise holds its payload
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_id_q    <= win_id;
      out_data_q  <= win_data;
      out_rd_q    <= win_rd;
      out_we_q    <= win_we;
    end else if (result_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign result_valid_o = out_valid_q;
  assign result_id_o    = out_id_q;
  assign result_data_o  = out_data_q;
  assign result_rd_o    = out_rd_q;
  assign result_we_o    = out_we_q;
  assign result_exc_o   = 1'b0;
  assign protocol_err_o = err_q;

endmodule
